writeback_regfile: RTL and testbench
====================================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter DATA_W, default 16, width of aluout/memout/pcout/npc, register contents, VSR1 and VSR2.
REQ-002 Parameter REG_ADDR_W, default 3, register address width; register count NUM_REGS = 2**REG_ADDR_W.
REQ-003 Parameter BYPASS, default 1, enables write-to-read forwarding (1) or read-old-value behaviour (0).
REQ-004 Reset is synchronous and active-high; the block uses one clock.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable_writeback  input  1  qualifies a register write and a psr update this cycle.
REQ-008 W_control  input  2  write-data source select.
REQ-009 aluout  input  DATA_W  ALU result.
REQ-010 memout  input  DATA_W  memory load data.
REQ-011 pcout  input  DATA_W  computed PC/address value.
REQ-012 npc  input  DATA_W  next-PC value, used for link writes.
REQ-013 dr  input  REG_ADDR_W  destination register index.
REQ-014 sr1  input  REG_ADDR_W  source register 1 index.
REQ-015 sr2  input  REG_ADDR_W  source register 2 index.
REQ-016 VSR1  output  DATA_W  registered value of register sr1.
REQ-017 VSR2  output  DATA_W  registered value of register sr2.
REQ-018 psr  output  3  condition codes {N,Z,P} of the last written value.

Function
REQ-019 The write data SHALL be selected by W_control: 0 aluout, 1 pcout, 2 memout, 3 npc.
REQ-020 When enable_writeback=1, the block SHALL write the write data into register dr on the rising edge.
REQ-021 When enable_writeback=1, psr SHALL be updated on the same edge:
- 3'b100 if write data MSB=1
- 3'b010 if write data = 0
- 3'b001 otherwise
REQ-022 When enable_writeback=0, the register array and psr SHALL hold their values.
REQ-023 VSR1 and VSR2 SHALL be registered every cycle from sr1/sr2, with one-cycle latency regardless of enable_writeback.
REQ-024 With BYPASS=1, when enable_writeback=1 and sr1==dr, VSR1 SHALL take the write data on that edge; sr2 and VSR2 SHALL behave the same way.
REQ-025 With BYPASS=0, a read of the register being written in the same cycle SHALL return its pre-write contents.
REQ-026 sr1==sr2 SHALL return identical values on VSR1 and VSR2.
REQ-027 All index values 0..NUM_REGS-1 SHALL be valid; no address wrap or aliasing occurs.
REQ-028 The write data is exactly DATA_W bits; there is no arithmetic, extension or truncation.

Reset
REQ-029 While reset=1 on a rising edge, all NUM_REGS registers, VSR1, VSR2 and psr SHALL become 0.
REQ-030 Reset SHALL take priority over a simultaneous enable_writeback; that write is discarded.
REQ-031 Reset asserted mid-sequence SHALL discard any in-flight read; the first valid VSR outputs appear one edge after reset deasserts.

Structure
REQ-032 A shared package writeback_regfile_pkg SHALL hold the following, so that the interface/agent packages can import them:
- W_control encoding enum (WB_ALU, WB_PC, WB_MEM, WB_NPC)
- psr encoding constants
- default parameter values
REQ-033 The storage array SHALL be one sub-module, wb_reg_array, providing:
- one synchronous write port
- two combinational read ports
REQ-034 The top level SHALL contain:
- source mux
- psr logic
- bypass compare
- output registers

Verification
REQ-035 Reset then idle: assert reset 1 cycle; read sr1=0..7 -> VSR1=0x0000 for every index, psr=3'b000.
REQ-036 Source select: write dr=3 with W_control=0 aluout=0x1234, then W_control=3 npc=0x3001 to dr=4 -> reads give 0x1234 and 0x3001; psr=001 after each write.
REQ-037 psr: write memout=0x8000 (W_control=2) -> psr=100; write aluout=0x0000 -> psr=010; idle cycle with enable_writeback=0 -> psr stays 010.
REQ-038 Bypass: BYPASS=1, R5=0x1111, same-cycle write R5=0x2222 with sr1=sr2=5 -> VSR1=VSR2=0x2222 next cycle; BYPASS=0 -> 0x1111, then 0x2222 one cycle later.
REQ-039 Reset collision: enable_writeback=1, dr=2, aluout=0xBEEF, reset=1 same edge -> R2 reads 0x0000 after reset.
REQ-040 Width sweep: DATA_W=32, REG_ADDR_W=4; write dr=15 with 0xFFFF_FFFF -> read sr2=15 returns 0xFFFF_FFFF, psr=100.

Source files
------------

// File: rtl/writeback_regfile_pkg.sv
// Shared types and constants for the writeback/register-file slice.
// Imported by the RTL and by any interface or agent packages.
package writeback_regfile_pkg;

    localparam int WB_DATA_W_DEF   = 16;
    localparam int WB_REG_ADDR_DEF = 3;
    localparam int WB_BYPASS_DEF   = 1;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_PC  = 2'd1,
        WB_MEM = 2'd2,
        WB_NPC = 2'd3
    } wb_sel_e;

    localparam logic [2:0] PSR_NONE = 3'b000;
    localparam logic [2:0] PSR_N    = 3'b100;
    localparam logic [2:0] PSR_Z    = 3'b010;
    localparam logic [2:0] PSR_P    = 3'b001;

endpackage

// File: rtl/writeback_regfile_array.sv
// Register storage: one synchronous write port, two combinational reads.
// Reset clears every entry.
module wb_reg_array
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W_DEF,
    parameter int ADDR_W = WB_REG_ADDR_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: source mux, condition codes, register file and
// registered source-operand reads with optional write forwarding.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W_DEF,
    parameter int REG_ADDR_W = WB_REG_ADDR_DEF,
    parameter int BYPASS     = WB_BYPASS_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_writeback,
    input  logic [1:0]            W_control,
    input  logic [DATA_W-1:0]     aluout,
    input  logic [DATA_W-1:0]     memout,
    input  logic [DATA_W-1:0]     pcout,
    input  logic [DATA_W-1:0]     npc,
    input  logic [REG_ADDR_W-1:0] dr,
    input  logic [REG_ADDR_W-1:0] sr1,
    input  logic [REG_ADDR_W-1:0] sr2,
    output logic [DATA_W-1:0]     VSR1,
    output logic [DATA_W-1:0]     VSR2,
    output logic [2:0]            psr
);

    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] vsr1_d, vsr1_q;
    logic [DATA_W-1:0] vsr2_d, vsr2_q;
    logic [2:0]        psr_d, psr_q;
    logic              fwd1;
    logic              fwd2;

    always_comb begin
        wdata = aluout;
        unique case (wb_sel_e'(W_control))
            WB_ALU: wdata = aluout;
            WB_PC:  wdata = pcout;
            WB_MEM: wdata = memout;
            WB_NPC: wdata = npc;
        endcase
    end

    wb_reg_array #(
        .DATA_W (DATA_W),
        .ADDR_W (REG_ADDR_W)
    ) u_array (
        .clk_i    (clock),
        .rst_i    (reset),
        .we_i     (enable_writeback),
        .waddr_i  (dr),
        .wdata_i  (wdata),
        .raddr1_i (sr1),
        .raddr2_i (sr2),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    // Forwarding makes a same-edge write visible on the read outputs.
    assign fwd1 = (BYPASS != 0) && enable_writeback && (sr1 == dr);
    assign fwd2 = (BYPASS != 0) && enable_writeback && (sr2 == dr);

    always_comb begin
        vsr1_d = fwd1 ? wdata : rd1;
        vsr2_d = fwd2 ? wdata : rd2;
        psr_d  = psr_q;
        if (enable_writeback) begin
            unique case (1'b1)
                wdata[DATA_W-1]: psr_d = PSR_N;
                (wdata == '0):   psr_d = PSR_Z;
                default:         psr_d = PSR_P;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vsr1_q <= '0;
            vsr2_q <= '0;
            psr_q  <= PSR_NONE;
        end else begin
            vsr1_q <= vsr1_d;
            vsr2_q <= vsr2_d;
            psr_q  <= psr_d;
        end
    end

    assign VSR1 = vsr1_q;
    assign VSR2 = vsr2_q;
    assign psr  = psr_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: forwarding, non-forwarding
// and 32-bit/16-entry instances driven from shared stimulus.
module tb_writeback_regfile;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  wc = 2'd0;
    logic [15:0] alu = '0, mem = '0, pc = '0, np = '0;
    logic [2:0]  dr = '0, sr1 = '0, sr2 = '0;
    logic [15:0] b_v1, b_v2, n_v1, n_v2;
    logic [2:0]  b_psr, n_psr;

    logic        w_en = 1'b0;
    logic [1:0]  w_wc = 2'd0;
    logic [31:0] w_alu = '0, w_mem = '0, w_pc = '0, w_np = '0;
    logic [3:0]  w_dr = '0, w_sr1 = '0, w_sr2 = '0;
    logic [31:0] w_v1, w_v2;
    logic [2:0]  w_psr;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    writeback_regfile #(.BYPASS(1)) dut_byp (
        .clock(clock), .reset(reset), .enable_writeback(en),
        .W_control(wc), .aluout(alu), .memout(mem), .pcout(pc),
        .npc(np), .dr(dr), .sr1(sr1), .sr2(sr2),
        .VSR1(b_v1), .VSR2(b_v2), .psr(b_psr)
    );

    writeback_regfile #(.BYPASS(0)) dut_nob (
        .clock(clock), .reset(reset), .enable_writeback(en),
        .W_control(wc), .aluout(alu), .memout(mem), .pcout(pc),
        .npc(np), .dr(dr), .sr1(sr1), .sr2(sr2),
        .VSR1(n_v1), .VSR2(n_v2), .psr(n_psr)
    );

    writeback_regfile #(.DATA_W(32), .REG_ADDR_W(4)) dut_wide (
        .clock(clock), .reset(reset), .enable_writeback(w_en),
        .W_control(w_wc), .aluout(w_alu), .memout(w_mem),
        .pcout(w_pc), .npc(w_np), .dr(w_dr), .sr1(w_sr1),
        .sr2(w_sr2), .VSR1(w_v1), .VSR2(w_v2), .psr(w_psr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // reset and idle reads
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_psr", 32'(b_psr), 32'h0);
        chk("rst_v1", 32'(b_v1), 32'h0);
        chk("rst_wpsr", 32'(w_psr), 32'h0);
        for (int i = 0; i < 8; i++) begin
            sr1 = 3'(i);
            tick();
            chk($sformatf("idle_r%0d", i), 32'(b_v1), 32'h0);
        end

        // source select
        en = 1'b1; dr = 3'd3; wc = 2'd0; alu = 16'h1234; np = 16'h7777;
        tick();
        chk("alu_psr", 32'(b_psr), 32'h1);
        dr = 3'd4; wc = 2'd3; np = 16'h3001; alu = 16'h5555;
        tick();
        chk("npc_psr", 32'(b_psr), 32'h1);
        dr = 3'd6; wc = 2'd1; pc = 16'h0042;
        tick();
        en = 1'b0; sr1 = 3'd3; sr2 = 3'd4;
        tick();
        chk("rd_alu", 32'(b_v1), 32'h1234);
        chk("rd_npc", 32'(b_v2), 32'h3001);
        sr1 = 3'd6;
        tick();
        chk("rd_pc", 32'(b_v1), 32'h0042);

        // condition codes
        en = 1'b1; dr = 3'd1; wc = 2'd2; mem = 16'h8000;
        tick();
        chk("psr_n", 32'(b_psr), 32'h4);
        wc = 2'd0; alu = 16'h0000;
        tick();
        chk("psr_z", 32'(b_psr), 32'h2);
        en = 1'b0; alu = 16'h0001;
        tick();
        chk("psr_hold", 32'(b_psr), 32'h2);

        // boundary indices
        en = 1'b1; wc = 2'd0; dr = 3'd0; alu = 16'h00AA;
        tick();
        dr = 3'd7; alu = 16'h7F00;
        tick();
        en = 1'b0; sr1 = 3'd0; sr2 = 3'd7;
        tick();
        chk("rd_r0", 32'(b_v1), 32'h00AA);
        chk("rd_r7", 32'(b_v2), 32'h7F00);
        chk("ib_psr", 32'(b_psr), 32'h1);

        // forwarding vs old value
        en = 1'b1; dr = 3'd5; alu = 16'h1111;
        tick();
        alu = 16'h2222; sr1 = 3'd5; sr2 = 3'd5;
        tick();
        chk("byp_v1", 32'(b_v1), 32'h2222);
        chk("byp_v2", 32'(b_v2), 32'h2222);
        chk("nob_v1", 32'(n_v1), 32'h1111);
        chk("nob_v2", 32'(n_v2), 32'h1111);
        en = 1'b0;
        tick();
        chk("nob_late", 32'(n_v1), 32'h2222);
        chk("byp_hold", 32'(b_v2), 32'h2222);

        // reset beats a simultaneous write
        en = 1'b1; dr = 3'd2; alu = 16'hBEEF; reset = 1'b1;
        tick();
        chk("rc_v1", 32'(b_v1), 32'h0);
        chk("rc_psr", 32'(b_psr), 32'h0);
        reset = 1'b0; en = 1'b0; sr1 = 3'd2; sr2 = 3'd3;
        tick();
        chk("rc_r2", 32'(b_v1), 32'h0);
        chk("rc_r3", 32'(b_v2), 32'h0);
        chk("rc_nob", 32'(n_v1), 32'h0);

        // wide instance
        w_en = 1'b1; w_dr = 4'd15; w_wc = 2'd0; w_alu = 32'hFFFF_FFFF;
        tick();
        chk("w_psr", 32'(w_psr), 32'h4);
        w_dr = 4'd8; w_wc = 2'd2; w_mem = 32'h0001_0000;
        tick();
        chk("w_psr_p", 32'(w_psr), 32'h1);
        w_en = 1'b0; w_sr2 = 4'd15; w_sr1 = 4'd7;
        tick();
        chk("w_r15", w_v2, 32'hFFFF_FFFF);
        chk("w_r7", w_v1, 32'h0);
        w_sr1 = 4'd8; w_sr2 = 4'd0;
        tick();
        chk("w_r8", w_v1, 32'h0001_0000);
        chk("w_r0", w_v2, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
